// File: rtl/count_pwm_gen_if.sv
// count_pwm_gen_if: counter/duty inputs and PWM/status outputs of count_pwm_gen.
interface count_pwm_gen_if #(parameter int LAP_W = 8);
  logic enable;
  logic [3:0] count;
  logic [3:0] duty_in;
  logic duty_wr;
  logic duty_ack;
  logic pwm_out;
  logic wrap;
  logic [LAP_W-1:0] lap_count;
  logic running;
  logic stalled;
  modport master (
    output enable, count, duty_in, duty_wr,
    input duty_ack, pwm_out, wrap, lap_count, running, stalled
  );
  modport slave (
    input enable, count, duty_in, duty_wr,
    output duty_ack, pwm_out, wrap, lap_count, running, stalled
  );
endinterface

// File: rtl/count_pwm_gen.sv
// count_pwm_gen: phase-tracking PWM from a mod-16 count with wrap/lap/discontinuity detection.
// Optional stall detector enabled by defining COUNT_PWM_STALL_DETECT_EN.
module count_pwm_gen #(
  parameter int LAP_W = 8,
  parameter int STALL_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  count_pwm_gen_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2;
  logic [1:0] state, nxt;
  logic [3:0] prev, duty_active, duty_pend, duty_eff;
  logic [LAP_W-1:0] lap;
  logic pend, ev, disc, hold, active, commit, stall_nxt;
  logic pwm, wrap_r, ack, running, stalled;
  assign ev = prev == 4'd15 && bus.count == 4'd0;
  assign hold = bus.count == prev;
  assign disc = !hold && bus.count != prev + 4'd1;
  assign active = state != IDLE;
  assign commit = ev && active && pend;
  // A duty committed this cycle already governs this cycle's compare.
  assign duty_eff = commit ? duty_pend : duty_active;
  always_comb
    nxt = !bus.enable ? IDLE :
          state == IDLE ? SYNC :
          state == SYNC ? (ev ? RUN : SYNC) :
          state == RUN ? (disc ? SYNC : RUN) : IDLE;
`ifdef COUNT_PWM_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);
  logic [SW-1:0] stall_cnt, stall_cnt_nxt;
  always_comb
    stall_cnt_nxt = (state == RUN && hold) ?
                    (stall_cnt == SW'(STALL_CYCLES) ? stall_cnt : stall_cnt + 1'b1) : '0;
  assign stall_nxt = nxt == RUN && hold && stall_cnt_nxt == SW'(STALL_CYCLES);
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_cnt <= '0;
    else stall_cnt <= stall_cnt_nxt;
`else
  logic unused_stall;
  assign unused_stall = STALL_CYCLES != 0;
  assign stall_nxt = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      prev <= '0;
      duty_active <= '0;
      duty_pend <= '0;
      pend <= 1'b0;
      lap <= '0;
      pwm <= 1'b0;
      wrap_r <= 1'b0;
      ack <= 1'b0;
      running <= 1'b0;
      stalled <= 1'b0;
    end else begin
      state <= nxt;
      prev <= bus.count;
      running <= nxt == RUN;
      stalled <= stall_nxt;
      pwm <= nxt == RUN && !stall_nxt && bus.count < duty_eff;
      wrap_r <= ev && active;
      ack <= commit;
      if (ev && active) lap <= lap + 1'b1;
      if (commit) duty_active <= duty_pend;
      // A write colliding with a commit becomes the next pending value.
      if (bus.duty_wr) begin
        duty_pend <= bus.duty_in;
        pend <= 1'b1;
      end else if (commit) pend <= 1'b0;
    end
  assign bus.pwm_out = pwm;
  assign bus.wrap = wrap_r;
  assign bus.duty_ack = ack;
  assign bus.lap_count = lap;
  assign bus.running = running;
  assign bus.stalled = stalled;
endmodule

// File: tb/tb_count_pwm_gen.sv
// tb_count_pwm_gen: directed self-checking bench for count_pwm_gen.
module tb_count_pwm_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [3:0] cnt = 4'd0;
  logic [7:0] lap_exp = 8'd0;
  count_pwm_gen_if #(.LAP_W(8)) ifc ();
  count_pwm_gen #(.LAP_W(8), .STALL_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(ifc));
  always #5 clk = ~clk;

  task automatic cyc(input logic [3:0] c, input logic wr, input logic [3:0] v);
    cnt = c;
    ifc.count = c;
    ifc.duty_wr = wr;
    ifc.duty_in = v;
    @(posedge clk);
    #1;
    ifc.duty_wr = 1'b0;
  endtask

  task automatic adv(input logic wr, input logic [3:0] v);
    cyc(cnt + 4'd1, wr, v);
  endtask

  task automatic period(input logic [3:0] d, input logic ack_exp, input int wr_at, input logic [3:0] wr_val);
    for (int i = 0; i < 16; i++) begin
      adv(wr_at == i, wr_val);
      total++;
      if (ifc.pwm_out !== (cnt < d)) begin
        bad++;
        $display("FAIL period_pwm d=%0d cnt=%0d: got %0b exp %0b", d, cnt, ifc.pwm_out, cnt < d);
      end
      if (i == 0) begin
        lap_exp++;
        total += 4;
        if (ifc.wrap !== 1'b1) begin bad++; $display("FAIL period_wrap: got %0b exp 1", ifc.wrap); end
        if (ifc.duty_ack !== ack_exp) begin bad++; $display("FAIL period_ack: got %0b exp %0b", ifc.duty_ack, ack_exp); end
        if (ifc.lap_count !== lap_exp) begin bad++; $display("FAIL period_lap: got %0d exp %0d", ifc.lap_count, lap_exp); end
        if (ifc.running !== 1'b1) begin bad++; $display("FAIL period_running: got %0b exp 1", ifc.running); end
      end else begin
        total += 2;
        if (ifc.wrap !== 1'b0) begin bad++; $display("FAIL period_nowrap cnt=%0d: got %0b exp 0", cnt, ifc.wrap); end
        if (ifc.duty_ack !== 1'b0) begin bad++; $display("FAIL period_noack cnt=%0d: got %0b exp 0", cnt, ifc.duty_ack); end
      end
    end
  endtask

  task automatic test_reset;
    ifc.enable = 1'b0;
    ifc.count = 4'd0;
    ifc.duty_in = 4'd0;
    ifc.duty_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ifc.pwm_out, ifc.wrap, ifc.duty_ack, ifc.lap_count, ifc.running, ifc.stalled} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %0h exp 0", {ifc.pwm_out, ifc.wrap, ifc.duty_ack, ifc.lap_count, ifc.running, ifc.stalled});
    end
    reset = 1'b0;
  endtask

  task automatic test_first_wrap;
    ifc.enable = 1'b1;
    cyc(4'd0, 1'b0, 4'd0);
    for (int i = 1; i < 16; i++) adv(i == 3, 4'd4);
    total += 2;
    if (ifc.running !== 1'b0) begin bad++; $display("FAIL sync_running: got %0b exp 0", ifc.running); end
    if (ifc.pwm_out !== 1'b0) begin bad++; $display("FAIL sync_pwm: got %0b exp 0", ifc.pwm_out); end
    period(4'd4, 1'b1, -1, 4'd0);
  endtask

  task automatic test_duty_update;
    period(4'd4, 1'b0, 6, 4'd12);
    period(4'd12, 1'b1, -1, 4'd0);
  endtask

  task automatic test_preload;
    for (int i = 0; i < 7; i++) adv(1'b0, 4'd0);
    lap_exp++;
    cyc(4'd10, 1'b0, 4'd0);
    total += 3;
    if (ifc.running !== 1'b0) begin bad++; $display("FAIL preload_running: got %0b exp 0", ifc.running); end
    if (ifc.pwm_out !== 1'b0) begin bad++; $display("FAIL preload_pwm: got %0b exp 0", ifc.pwm_out); end
    if (ifc.wrap !== 1'b0) begin bad++; $display("FAIL preload_wrap: got %0b exp 0", ifc.wrap); end
    for (int i = 0; i < 5; i++) begin
      adv(1'b0, 4'd0);
      total++;
      if (ifc.pwm_out !== 1'b0) begin bad++; $display("FAIL resync_pwm cnt=%0d: got %0b exp 0", cnt, ifc.pwm_out); end
    end
    period(4'd12, 1'b0, -1, 4'd0);
  endtask

  task automatic test_back_to_back;
    period(4'd12, 1'b0, 8, 4'd7);
    period(4'd7, 1'b1, 0, 4'd9);
    period(4'd9, 1'b1, -1, 4'd0);
    period(4'd9, 1'b0, -1, 4'd0);
  endtask

  task automatic test_lap_wrap;
    for (int k = 0; k < 300 && lap_exp != 8'd0; k++) period(4'd9, 1'b0, -1, 4'd0);
    total++;
    if (ifc.lap_count !== 8'd0) begin bad++; $display("FAIL lap_rollover: got %0d exp 0", ifc.lap_count); end
  endtask

  task automatic test_enable_drop;
    for (int i = 0; i < 6; i++) adv(1'b0, 4'd0);
    lap_exp++;
    ifc.enable = 1'b0;
    adv(1'b0, 4'd0);
    total += 3;
    if (ifc.running !== 1'b0) begin bad++; $display("FAIL disable_running: got %0b exp 0", ifc.running); end
    if (ifc.pwm_out !== 1'b0) begin bad++; $display("FAIL disable_pwm: got %0b exp 0", ifc.pwm_out); end
    if (ifc.lap_count !== lap_exp) begin bad++; $display("FAIL disable_lap: got %0d exp %0d", ifc.lap_count, lap_exp); end
    for (int i = 0; i < 11; i++) begin
      adv(1'b0, 4'd0);
      total += 2;
      if (ifc.wrap !== 1'b0) begin bad++; $display("FAIL idle_wrap cnt=%0d: got %0b exp 0", cnt, ifc.wrap); end
      if (ifc.lap_count !== lap_exp) begin bad++; $display("FAIL idle_lap cnt=%0d: got %0d exp %0d", cnt, ifc.lap_count, lap_exp); end
    end
  endtask

  task automatic test_stall;
    logic stall_exp;
`ifdef COUNT_PWM_STALL_DETECT_EN
    stall_exp = 1'b1;
`else
    stall_exp = 1'b0;
`endif
    ifc.enable = 1'b1;
    while (cnt != 4'd15) adv(1'b0, 4'd0);
    for (int i = 0; i < 6; i++) adv(1'b0, 4'd0);
    lap_exp++;
    total++;
    if (ifc.lap_count !== lap_exp) begin bad++; $display("FAIL reenable_lap: got %0d exp %0d", ifc.lap_count, lap_exp); end
    for (int i = 0; i < 15; i++) cyc(4'd5, 1'b0, 4'd0);
    total += 2;
    if (ifc.stalled !== 1'b0) begin bad++; $display("FAIL stall_early: got %0b exp 0", ifc.stalled); end
    if (ifc.pwm_out !== 1'b1) begin bad++; $display("FAIL stall_early_pwm: got %0b exp 1", ifc.pwm_out); end
    repeat (2) cyc(4'd5, 1'b0, 4'd0);
    total += 3;
    if (ifc.stalled !== stall_exp) begin bad++; $display("FAIL stall_set: got %0b exp %0b", ifc.stalled, stall_exp); end
    if (ifc.pwm_out !== !stall_exp) begin bad++; $display("FAIL stall_pwm: got %0b exp %0b", ifc.pwm_out, !stall_exp); end
    if (ifc.running !== 1'b1) begin bad++; $display("FAIL stall_running: got %0b exp 1", ifc.running); end
    adv(1'b0, 4'd0);
    total += 2;
    if (ifc.stalled !== 1'b0) begin bad++; $display("FAIL stall_clear: got %0b exp 0", ifc.stalled); end
    if (ifc.pwm_out !== 1'b1) begin bad++; $display("FAIL stall_clear_pwm: got %0b exp 1", ifc.pwm_out); end
  endtask

  task automatic test_duty_bounds;
    while (cnt != 4'd15) adv(cnt == 4'd7, 4'd15);
    period(4'd15, 1'b1, 3, 4'd0);
    period(4'd0, 1'b1, -1, 4'd0);
  endtask

  task automatic test_async_reset;
    period(4'd0, 1'b0, 4, 4'd10);
    adv(1'b0, 4'd0);
    total++;
    if (ifc.pwm_out !== 1'b1) begin bad++; $display("FAIL pre_reset_pwm: got %0b exp 1", ifc.pwm_out); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ifc.pwm_out, ifc.wrap, ifc.duty_ack, ifc.lap_count, ifc.running, ifc.stalled} !== 13'd0) begin
      bad++;
      $display("FAIL async_reset: got %0h exp 0", {ifc.pwm_out, ifc.wrap, ifc.duty_ack, ifc.lap_count, ifc.running, ifc.stalled});
    end
  endtask

  initial begin
    test_reset;
    test_first_wrap;
    test_duty_update;
    test_preload;
    test_back_to_back;
    test_lap_wrap;
    test_enable_drop;
    test_stall;
    test_duty_bounds;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/count_pwm_gen.md
# count_pwm_gen

Downstream consumer of the 4-bit mod-16 counter output. Watches the free-running `count` value, tracks its phase, and produces a glitch-free PWM waveform whose duty is compared against `count`. Also flags each 15→0 wrap, keeps a lap tally, and detects counter discontinuities such as preloads or resets. Duty updates are double-buffered and committed only on a wrap boundary.

## Interface
- `LAP_W`, 8, width of lap counter
- `STALL_CYCLES`, 16, consecutive unchanged-count cycles before `stalled` asserts (used only with stall detect)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `enable`  in  1  block enable; low forces IDLE
- `count`  in  4  counter value from the mod-16 counter, synchronous to `clk`
- `duty_in`  in  4  requested duty, 0..15 high cycles per 16
- `duty_wr`  in  1  single-cycle write strobe for `duty_in`
- `duty_ack`  out  1  one-cycle pulse when a pending duty is committed
- `pwm_out`  out  1  registered PWM output
- `wrap`  out  1  one-cycle pulse per detected 15→0 transition
- `lap_count`  out  LAP_W  number of wraps counted since reset
- `running`  out  1  high while FSM is in RUN
- `stalled`  out  1  count held too long (see Configuration)

## Operation
- `prev_count` register samples `count` every cycle. Reset value is 0.
- Wrap event: `prev_count==15 && count==0`.
- Step is legal when `count==prev_count` (hold) or `count==prev_count+1 mod 16`. Any other value is a discontinuity.
- FSM states: IDLE, SYNC, RUN. Reset state is IDLE.
  - IDLE → SYNC when `enable=1`.
  - SYNC → RUN on a wrap event.
  - RUN → SYNC on a discontinuity.
  - Any state → IDLE when `enable=0`. This has priority over every other transition.
- PWM:
  - In RUN, `pwm_out <= (count < duty_active)`.
  - In IDLE and SYNC, `pwm_out <= 0`.
  - `duty_active=0` gives constant low. `duty_active=15` gives 15 high cycles out of 16.
- Duty buffering:
  - `duty_wr=1` loads `duty_pend <= duty_in` and sets `pend`. This is accepted in any state.
  - A repeat write while `pend` is set overwrites the pending value; last write wins.
  - On a wrap event in SYNC or RUN with `pend=1`: `duty_active <= duty_pend`, `pend` clears, and `duty_ack` pulses.
  - If `duty_wr` and a commit happen in the same cycle, the old `duty_pend` commits. The new value becomes pending and `pend` stays 1.
- Lap counter:
  - Increments on every wrap event in SYNC or RUN, including the SYNC→RUN transition.
  - Wraps modulo 2^LAP_W.
  - Holds in IDLE. Cleared only by `reset`.
- `wrap` pulses on every wrap event in SYNC or RUN. It never pulses in IDLE.

## Timing
- All outputs are registered. Reset values:
  - `pwm_out=0`, `wrap=0`, `duty_ack=0`, `lap_count=0`, `running=0`, `stalled=0`
  - internal `duty_active=0`, `duty_pend=0`, `pend=0`
- `pwm_out` lags `count` by 1 cycle.
- Wrap event in cycle N (the cycle where `count=0` is first seen):
  - `wrap`, `duty_ack`, and the `lap_count` update are visible in N+1.
  - The new `duty_active` governs `pwm_out` from the compare in cycle N onward. It is therefore visible at `pwm_out` in N+1.
- `running` rises in N+1 after the SYNC→RUN wrap. It falls the cycle after a discontinuity or after `enable` drops.
- Discontinuity in cycle N: `pwm_out=0` from N+1, and no wrap is credited. A jump from 15 directly to 0 via preload is indistinguishable from a wrap and is treated as a wrap.
- Asserting `reset` mid-period clears outputs immediately, without waiting for `clk`.

## Configuration
- `COUNT_PWM_STALL_DETECT_EN` defined:
  - In RUN, a saturating counter tracks consecutive cycles with `count==prev_count`.
  - `stalled` rises the cycle after the counter reaches `STALL_CYCLES`.
  - `stalled` clears the cycle after `count` changes or the FSM leaves RUN.
  - While `stalled=1`, `pwm_out` is forced to 0.
- Not defined: no stall logic is built, `stalled` is tied 0, and `pwm_out` follows the compare normally.

## Test plan
- Reset, `enable=1`, count 0..15 free-running, `duty_in=4` written before the first wrap → first wrap gives `running=1`, `duty_ack`, `lap_count=1`. Every later period has `pwm_out` high exactly 4 cycles (count 0..3, delayed 1 cycle).
- Write `duty_in=12` mid-period with current duty 4 → remainder of that period still 4-high. The next period is 12-high, and `duty_ack` coincides with `wrap`.
- Counter preloaded from 6 to 10 in RUN → `running=0` next cycle, `pwm_out=0`, no `wrap`. Re-enters RUN at the following 15→0.
- `duty_wr` (value 9) in the same cycle as the wrap event, with 7 pending → 7 commits with `duty_ack`. 9 stays pending and commits at the next wrap.
- 256 wraps with `LAP_W=8` → `lap_count` returns to 0. Dropping `enable` mid-period → `pwm_out=0` and `running=0` next cycle, and `lap_count` holds.
- With `COUNT_PWM_STALL_DETECT_EN`: count held at 5 for 16 cycles in RUN → `stalled=1`, `pwm_out=0`. Count resuming to 6 → `stalled=0` next cycle.
